// File: rtl/router_pkg.sv
// Shared constants and types for the router PE port: packet geometry,
// packet-field indices and the error-counter width.
package router_pkg;

   localparam int PKT_W       = 64;
   localparam int VC_BIT      = 63;
   localparam int PAYLOAD_MSB = 62;
   localparam int PAYLOAD_LSB = 0;
   localparam int ERR_CNT_W   = 8;

   typedef logic vc_t;

endpackage

// File: rtl/pe_vc_buf.sv
// Two one-entry packet slots, one per virtual channel, each with a full bit.
// Writes and read-clears are indexed by VC and always target opposite slots.
module pe_vc_buf
   import router_pkg::*;
#(
   parameter int PKT_W = router_pkg::PKT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  vc_t              wr_vc,
   input  logic [PKT_W-1:0] wr_data,
   input  logic             rd_clr,
   input  vc_t              rd_vc,
   output logic [1:0]       full,
   output logic [PKT_W-1:0] rd_data
);

   logic [PKT_W-1:0] slot [2];

   always_ff @(posedge clk) begin
      if (reset) begin
         full    <= 2'b00;
         slot[0] <= '0;
         slot[1] <= '0;
      end else begin
         if (wr_en) begin
            slot[wr_vc] <= wr_data;
            full[wr_vc] <= 1'b1;
         end
         if (rd_clr) begin
            full[rd_vc] <= 1'b0;
         end
      end
   end

   assign rd_data = slot[rd_vc];

endmodule

// File: rtl/router_pe_port.sv
// Two-phase PE port between a NIC and the router core. The polarity p picks
// the VC facing the NIC; the core side always works on the other VC.
// Optional VC-mismatch checking is enabled by defining ROUTER_PE_PORT_ERR_EN.
module router_pe_port
   import router_pkg::*;
#(
   parameter int PKT_W  = router_pkg::PKT_W,
   parameter int VC_BIT = router_pkg::VC_BIT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 net_so,
   output logic                 net_ro,
   input  logic [PKT_W-1:0]     net_do,
   output logic                 net_polarity,
   output logic                 net_si,
   input  logic                 net_ri,
   output logic [PKT_W-1:0]     net_di,
   output logic                 rtr_in_valid,
   input  logic                 rtr_in_ready,
   output logic [PKT_W-1:0]     rtr_in_data,
   input  logic                 rtr_out_valid,
   output logic                 rtr_out_ready,
   input  logic [PKT_W-1:0]     rtr_out_data,
   output logic                 err_vc,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   vc_t              p;
   vc_t              p_n;
   logic [1:0]       in_full;
   logic [1:0]       out_full;
   logic             in_wr;
   logic             in_rd;
   logic             out_wr;
   logic [PKT_W-1:0] out_rd_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         p <= 1'b0;
      end else begin
         p <= ~p;
      end
   end

   assign p_n          = ~p;
   assign net_polarity = p;

   // NIC side works on VC p, core side on VC ~p, so no slot is touched twice
   assign net_ro        = ~in_full[p];
   assign in_wr         = net_so & net_ro;
   assign rtr_in_valid  = in_full[p_n];
   assign in_rd         = rtr_in_valid & rtr_in_ready;

   assign rtr_out_ready = ~out_full[p_n];
   assign out_wr        = rtr_out_valid & rtr_out_ready;
   assign net_si        = out_full[p] & net_ri;
   assign net_di        = net_si ? out_rd_data : '0;

   pe_vc_buf #(.PKT_W(PKT_W)) u_ingress (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (in_wr),
      .wr_vc   (p),
      .wr_data (net_do),
      .rd_clr  (in_rd),
      .rd_vc   (p_n),
      .full    (in_full),
      .rd_data (rtr_in_data)
   );

   pe_vc_buf #(.PKT_W(PKT_W)) u_egress (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (out_wr),
      .wr_vc   (p_n),
      .wr_data (rtr_out_data),
      .rd_clr  (net_si),
      .rd_vc   (p),
      .full    (out_full),
      .rd_data (out_rd_data)
   );

`ifdef ROUTER_PE_PORT_ERR_EN
   logic vc_mismatch;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // A packet captured in phase p must carry VC p; it is stored regardless
   assign vc_mismatch = in_wr & (net_do[VC_BIT] != p);

   always_ff @(posedge clk) begin
      if (reset) begin
         err_vc  <= 1'b0;
         err_cnt <= '0;
      end else if (vc_mismatch) begin
         err_vc  <= 1'b1;
         err_cnt <= sat_inc(err_cnt);
      end
   end
`else
   assign err_vc  = 1'b0;
   assign err_cnt = '0;
`endif

endmodule

// File: doc/router_pe_port.md
ROUTER_PE_PORT -- requirements
Module: router_pe_port

Interface
REQ-001 The block SHALL have parameter PKT_W, default 64, packet width in bits.
REQ-002 The block SHALL have parameter VC_BIT, default 63, index of the virtual-channel bit within a packet.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 net_so  input  1  NIC has a packet for the router.
REQ-006 net_ro  output  1  router can accept a packet from the NIC.
REQ-007 net_do  input  PKT_W  packet from the NIC.
REQ-008 net_polarity  output  1  current external phase, driven to the NIC.
REQ-009 net_si  output  1  router is sending a packet to the NIC.
REQ-010 net_ri  input  1  NIC input buffer is empty.
REQ-011 net_di  output  PKT_W  packet to the NIC.
REQ-012 rtr_in_valid / rtr_in_ready / rtr_in_data  output / input / PKT_W  ingress packet to the router core.
REQ-013 rtr_out_valid / rtr_out_ready / rtr_out_data  input / output / PKT_W  egress packet from the router core.
REQ-014 err_vc  output  1  sticky VC-mismatch flag; err_cnt  output  8  mismatch count.

Function
REQ-015 The polarity register p SHALL toggle every cycle; net_polarity = p.
REQ-016 The block SHALL hold one ingress buffer and one egress buffer per VC (index 0/1), one packet each, with a full bit.
REQ-017 External phase: net_ro SHALL equal NOT ingress_full[p].
REQ-018 Ingress capture: when net_so and net_ro, net_do SHALL be written to ingress[p] and ingress_full[p] set at the clock edge.
REQ-019 Internal phase: rtr_in_valid SHALL equal ingress_full[~p]; rtr_in_data SHALL equal ingress[~p].
REQ-020 When rtr_in_valid and rtr_in_ready, ingress_full[~p] SHALL clear at the clock edge.
REQ-021 rtr_out_ready SHALL equal NOT egress_full[~p]; when rtr_out_valid and rtr_out_ready, rtr_out_data SHALL be written to egress[~p].
REQ-022 net_si SHALL equal egress_full[p] AND net_ri; net_di SHALL equal egress[p] when net_si, else all zeros.
REQ-023 When net_si is high, egress_full[p] SHALL clear at the clock edge.
REQ-024 A buffer SHALL never be written and read in the same cycle: writes and reads of any one VC buffer occur in opposite phases.
REQ-025 Minimum latency NIC to core SHALL be one cycle: packet captured in phase p appears on rtr_in_* in the next cycle.
REQ-026 Minimum latency core to NIC SHALL be one cycle, under the same phase rule.
REQ-027 Held (unhandshaken) packets SHALL remain stable in their buffers indefinitely; there is no drop or timeout.
REQ-028 net_so while net_ro is low SHALL have no effect; the NIC is responsible for holding the packet.

Reset
REQ-029 While reset is high: p=0, all full bits=0, buffer contents=0, err_vc=0, err_cnt=0.
REQ-030 Reset outputs: net_ro=1, net_polarity=0, net_si=0, net_di=0, rtr_in_valid=0, rtr_out_ready=1.
REQ-031 Reset mid-transfer SHALL discard all buffered packets, with no partial delivery.
REQ-032 The first cycle after reset SHALL have p=0.

Configuration
REQ-033 The macro ROUTER_PE_PORT_ERR_EN SHALL control VC-mismatch error checking.
REQ-034 With ROUTER_PE_PORT_ERR_EN defined, an ingress capture whose net_do[VC_BIT] != p SHALL set err_vc (sticky until reset) and increment err_cnt, saturating at 255; the packet SHALL still be stored.
REQ-035 Without ROUTER_PE_PORT_ERR_EN, err_vc and err_cnt SHALL be constant 0 and the checking logic SHALL be absent.

Structure
REQ-036 A shared package router_pkg SHALL hold PKT_W, VC_BIT, and the packet-field index constants.
REQ-037 The per-VC buffer pair SHALL be a sub-module pe_vc_buf: two one-entry registers with full bits, a write port indexed by VC, and a read port indexed by VC.
REQ-038 pe_vc_buf SHALL be instantiated twice, once for ingress and once for egress.

Verification
REQ-039 Reset check: hold reset for 3 cycles, then release -> outputs per REQ-030, and p toggles 0,1,0,... from the first post-reset cycle.
REQ-040 Ingress: net_so=1 with net_do=0x0123456789ABCDEF (bit63=0) in the p=0 cycle, rtr_in_ready=1 -> rtr_in_valid=1 with that data the next cycle, then cleared.
REQ-041 Ingress backpressure: rtr_in_ready=0, a second packet offered in the next p=0 phase -> net_ro=0 in p=0 cycles; the first packet is held until rtr_in_ready=1.
REQ-042 Egress: rtr_out_data=0x8111111111111111 offered when p=0 (stored in VC1), net_ri=1 -> net_si=1 with net_di=0x8111111111111111 the next cycle (p=1); net_si=0 and net_di=0 after that.
REQ-043 Egress stall: net_ri=0 for 8 cycles -> net_si stays 0, the packet is held, and rtr_out_ready=0 for VC1 phases; setting net_ri=1 delivers the packet in the next matching phase.
REQ-044 With ROUTER_PE_PORT_ERR_EN defined: capture 0xFEDCBA9876543210 (bit63=1) in a p=0 cycle -> err_vc=1 and err_cnt=1; 300 such mismatches -> err_cnt=255.
